opll_write_sequencer: RTL and testbench

- Serialises YM2413 register writes (address, data) from on-chip requesters onto the OPLL core's CPU bus (CS_n, WR_n, A0, D).
- Enforces the chip's post-write wait times: 12 master cycles after an address write, 84 after a data write.
- Sits between the TinyTapeout control/IO logic and the OPLL core, so requesters never violate bus timing.
- Buffers writes in a small FIFO so bursts (e.g. patch loads) are accepted at full rate.

---
 rtl/opll_seq_pkg.sv | 33 +++
 rtl/opll_seq_fifo.sv | 56 +++++
 rtl/opll_write_sequencer.sv | 174 +++++++++++++++++
 tb/tb_opll_write_sequencer.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opll_seq_pkg.sv
// Shared types and default timing for the YM2413 write sequencer.
// Timing constants are in OPLL master-clock (cen) ticks.
package opll_seq_pkg;

   localparam int REG_ADDR_W     = 8;
   localparam int REG_DATA_W     = 8;
   localparam int SHADOW_ENTRIES = 64;

   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_STROBE_LEN = 2;
   localparam int DEF_ADDR_WAIT  = 12;
   localparam int DEF_DATA_WAIT  = 84;

   typedef enum logic [2:0] {
      IDLE,
      A_STB,
      A_WAIT,
      D_STB,
      D_WAIT
   } seq_state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_req_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/opll_seq_fifo.sv
// Synchronous FIFO with occupancy output; head_dat shows the oldest entry combinationally.
// Push is ignored when full, pop is ignored when empty; push and pop together keep the level.
module opll_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_vld,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop_rdy,
   output logic                   head_vld,
   output logic [WIDTH-1:0]       head_dat,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (level == LVL_W'(DEPTH));
   assign head_vld = (level != '0);
   assign head_dat = mem[rd_ptr];
   assign do_push  = push_vld && !full;
   assign do_pop   = pop_rdy && head_vld;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/opll_write_sequencer.sv
// Queues YM2413 (addr,data) writes and replays them on the OPLL CPU bus with chip wait times.
// Optional OPLL_SHADOW_SKIP_EN drops writes that repeat the last value sent to a register.
module opll_write_sequencer
   import opll_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int STROBE_LEN = DEF_STROBE_LEN,
   parameter int ADDR_WAIT  = DEF_ADDR_WAIT,
   parameter int DATA_WAIT  = DEF_DATA_WAIT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cen,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [REG_ADDR_W-1:0]       wr_addr,
   input  logic [REG_DATA_W-1:0]       wr_data,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy,
   output logic                        opll_cs_n,
   output logic                        opll_wr_n,
   output logic                        opll_a0,
   output logic [REG_DATA_W-1:0]       opll_d
);

   // Counters hold "ticks remaining minus one", so every phase must last at least one tick.
   localparam int CNT_MAX = max3(STROBE_LEN - 1, ADDR_WAIT - 1, DATA_WAIT - 1);
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STB_LD = CNT_W'(STROBE_LEN - 1);
   localparam logic [CNT_W-1:0] AW_LD  = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] DW_LD  = CNT_W'(DATA_WAIT - 1);

   seq_state_t              state;
   logic [CNT_W-1:0]        cnt;
   logic [REG_DATA_W-1:0]   hold_data;

   wr_req_t                 push_req;
   wr_req_t                 head;
   logic [$bits(wr_req_t)-1:0] head_dat;
   logic                    head_vld;
   logic                    fifo_full;
   logic                    pop;
   logic                    skip;

   assign push_req = {wr_addr, wr_data};
   assign head     = head_dat;
   assign wr_ready = !fifo_full;
   assign pop      = (state == IDLE) && head_vld;
   assign busy     = (state != IDLE) || head_vld;

   opll_seq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(wr_req_t))
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (wr_valid),
      .push_dat (push_req),
      .pop_rdy  (pop),
      .head_vld (head_vld),
      .head_dat (head_dat),
      .level    (fifo_level),
      .full     (fifo_full)
   );

`ifdef OPLL_SHADOW_SKIP_EN
   logic [REG_DATA_W-1:0]     shadow_mem [SHADOW_ENTRIES];
   logic [SHADOW_ENTRIES-1:0] shadow_vld;
   logic [5:0]                sh_idx;
   logic                      sh_in_range;

   assign sh_idx      = head.addr[5:0];
   assign sh_in_range = (head.addr < REG_ADDR_W'(8'h40));
   assign skip        = sh_in_range && shadow_vld[sh_idx] && (shadow_mem[sh_idx] == head.data);

   // Upper addresses would alias onto the low registers, so only 0x00-0x3F are tracked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_vld <= '0;
      end else if (pop && sh_in_range) begin
         shadow_vld[sh_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (pop && sh_in_range) begin
         shadow_mem[sh_idx] <= head.data;
      end
   end
`else
   assign skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         hold_data <= '0;
         opll_cs_n <= 1'b1;
         opll_wr_n <= 1'b1;
         opll_a0   <= 1'b0;
         opll_d    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // The pop clock itself is not a tick; strobe timing starts at the next cen.
               if (pop && !skip) begin
                  hold_data <= head.data;
                  opll_d    <= head.addr;
                  opll_a0   <= 1'b0;
                  opll_cs_n <= 1'b0;
                  opll_wr_n <= 1'b0;
                  cnt       <= STB_LD;
                  state     <= A_STB;
               end
            end
            A_STB: begin
               if (cen) begin
                  if (cnt == '0) begin
                     opll_cs_n <= 1'b1;
                     opll_wr_n <= 1'b1;
                     cnt       <= AW_LD;
                     state     <= A_WAIT;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            A_WAIT: begin
               if (cen) begin
                  if (cnt == '0) begin
                     opll_d    <= hold_data;
                     opll_a0   <= 1'b1;
                     opll_cs_n <= 1'b0;
                     opll_wr_n <= 1'b0;
                     cnt       <= STB_LD;
                     state     <= D_STB;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            D_STB: begin
               if (cen) begin
                  if (cnt == '0) begin
                     opll_cs_n <= 1'b1;
                     opll_wr_n <= 1'b1;
                     cnt       <= DW_LD;
                     state     <= D_WAIT;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            D_WAIT: begin
               if (cen) begin
                  if (cnt == '0) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: begin
               opll_cs_n <= 1'b1;
               opll_wr_n <= 1'b1;
               cnt       <= '0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Bench for opll_write_sequencer: bus monitor + scoreboard of expected (addr,data) pairs.
module tb_opll_write_sequencer;

   localparam int STB = 2;
   localparam int AW  = 12;
   localparam int DW  = 84;

   logic       clk;
   logic       rst;
   logic       cen;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] fifo_level;
   logic       busy;
   logic       opll_cs_n;
   logic       opll_wr_n;
   logic       opll_a0;
   logic [7:0] opll_d;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int cen_div = 1;
   int strobe_cnt = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int a_start;
      int a_end;
      int d_start;
      int d_end;
      bit shape_bad;
   } txn_t;

   exp_t sb_q[$];
   txn_t mon_q[$];

`ifdef OPLL_SHADOW_SKIP_EN
   bit         mvld [64];
   logic [7:0] mshadow [64];
`endif

   opll_write_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fifo_level (fifo_level),
      .busy       (busy),
      .opll_cs_n  (opll_cs_n),
      .opll_wr_n  (opll_wr_n),
      .opll_a0    (opll_a0),
      .opll_d     (opll_d)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // cen_div: 0 = cen held low, 1 = every clk, N = every Nth clk.
   initial begin
      cen = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cen = (cen_div == 1) || (cen_div > 1 && (cyc % cen_div) == 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got time=%0t required < 1000000", $time);
      $fatal(1);
   end

   // Bus monitor: assembles address+data strobe pairs and checks them against the scoreboard.
   initial begin : monitor
      txn_t       cur;
      int         phase;
      logic       prev_wr_n;
      logic       ref_a0;
      logic [7:0] ref_d;
      exp_t       e;
      phase = 0;
      prev_wr_n = 1'b1;
      ref_a0 = 1'b0;
      ref_d = 8'h00;
      cur = '{default: 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            phase = 0;
            prev_wr_n = 1'b1;
         end else begin
            if (prev_wr_n && !opll_wr_n) begin
               strobe_cnt++;
               ref_a0 = opll_a0;
               ref_d = opll_d;
               if (!opll_a0) begin
                  cur = '{default: 0};
                  if (phase != 0) cur.shape_bad = 1'b1;
                  cur.a = opll_d;
                  cur.a_start = cyc;
                  phase = 1;
               end else begin
                  if (phase != 2) cur.shape_bad = 1'b1;
                  cur.d = opll_d;
                  cur.d_start = cyc;
                  phase = 3;
               end
            end
            if (!opll_wr_n && (opll_cs_n !== 1'b0 || opll_a0 !== ref_a0 || opll_d !== ref_d))
               cur.shape_bad = 1'b1;
            if (!prev_wr_n && opll_wr_n) begin
               if (phase == 1) begin
                  cur.a_end = cyc;
                  phase = 2;
               end else if (phase == 3) begin
                  cur.d_end = cyc;
                  phase = 0;
                  total++;
                  if (sb_q.size() == 0) begin
                     bad++;
                     $display("FAIL sb_unexpected: got addr=%02h data=%02h, required no transaction", cur.a, cur.d);
                  end else begin
                     e = sb_q.pop_front();
                     if (cur.a !== e.a || cur.d !== e.d) begin
                        bad++;
                        $display("FAIL sb_txn: got addr=%02h data=%02h, required addr=%02h data=%02h",
                                 cur.a, cur.d, e.a, e.d);
                     end
                  end
                  total++;
                  if (cur.shape_bad !== 1'b0) begin
                     bad++;
                     $display("FAIL bus_shape: got glitch on cs_n/a0/d for addr=%02h, required stable strobes", cur.a);
                  end
                  mon_q.push_back(cur);
               end
            end
            prev_wr_n = opll_wr_n;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] d, output int acc);
      int  waitc;
      bit  skip;
      skip = 1'b0;
      acc = -1;
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr = a;
      wr_data = d;
      waitc = 0;
      while (!wr_ready && waitc < 1000) begin
         @(negedge clk);
         waitc++;
      end
      if (!wr_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout: got wr_ready=0 for 1000 clk, required 1");
         wr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      wr_valid = 1'b0;
`ifdef OPLL_SHADOW_SKIP_EN
      if (a < 8'h40) begin
         if (mvld[a[5:0]] && mshadow[a[5:0]] == d) skip = 1'b1;
         mvld[a[5:0]] = 1'b1;
         mshadow[a[5:0]] = d;
      end
`endif
      if (!skip) sb_q.push_back('{a: a, d: d});
   endtask

   task automatic wait_idle(input int limit, output int t);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy=1 after %0d clk, required 0", limit);
      end
   endtask

   task automatic clear_model();
      sb_q.delete();
`ifdef OPLL_SHADOW_SKIP_EN
      foreach (mvld[i]) mvld[i] = 1'b0;
`endif
   endtask

   task automatic test_reset();
      logic [14:0] got;
      logic [14:0] exp;
      exp = {1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
      tick(1);
      got = {opll_cs_n, opll_wr_n, opll_a0, opll_d, fifo_level, wr_ready, busy};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL reset_in: got %015b required %015b", got, exp);
      end
      rst = 1'b0;
      tick(3);
      got = {opll_cs_n, opll_wr_n, opll_a0, opll_d, fifo_level, wr_ready, busy};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL reset_out: got %015b required %015b", got, exp);
      end
   endtask

   task automatic test_single_write();
      int acc, t, n0;
      cen_div = 1;
      tick(2);
      n0 = mon_q.size();
      push(8'h10, 8'h55, acc);
      wait_idle(500, t);
      total++;
      if (t - acc < 100 || t - acc > 101) begin
         bad++;
         $display("FAIL single_busy: got busy fall after %0d clk, required 100..101", t - acc);
      end
      total++;
      if (mon_q.size() != n0 + 1) begin
         bad++;
         $display("FAIL single_count: got %0d transactions, required 1", mon_q.size() - n0);
      end else begin
         total++;
         if (mon_q[n0].a_end - mon_q[n0].a_start != STB) begin
            bad++;
            $display("FAIL single_a_len: got %0d clk, required %0d", mon_q[n0].a_end - mon_q[n0].a_start, STB);
         end
         total++;
         if (mon_q[n0].d_start - mon_q[n0].a_end != AW) begin
            bad++;
            $display("FAIL single_a_wait: got %0d clk, required %0d", mon_q[n0].d_start - mon_q[n0].a_end, AW);
         end
         total++;
         if (mon_q[n0].d_end - mon_q[n0].d_start != STB) begin
            bad++;
            $display("FAIL single_d_len: got %0d clk, required %0d", mon_q[n0].d_end - mon_q[n0].d_start, STB);
         end
      end
   endtask

   task automatic test_burst();
      int acc [5];
      int n0, t, rc, w;
      cen_div = 1;
      n0 = mon_q.size();
      for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 8'hA0 + 8'(i), acc[i]);
      total++;
      if (acc[4] - acc[0] != 4) begin
         bad++;
         $display("FAIL burst_rate: got 5 writes over %0d clk, required 4", acc[4] - acc[0]);
      end
      @(negedge clk);
      total++;
      if (fifo_level !== 3'd4 || wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL burst_full: got level=%0d ready=%b, required level=4 ready=0", fifo_level, wr_ready);
      end
      w = 0;
      while (!wr_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      rc = cyc;
      total++;
      if (rc - acc[0] != 102) begin
         bad++;
         $display("FAIL burst_ready: got ready back %0d clk after first accept, required 102", rc - acc[0]);
      end
      wait_idle(1000, t);
      total++;
      if (mon_q.size() != n0 + 5) begin
         bad++;
         $display("FAIL burst_count: got %0d transactions, required 5", mon_q.size() - n0);
      end else begin
         for (int i = 1; i < 5; i++) begin
            total++;
            if (mon_q[n0+i].a_start - mon_q[n0+i-1].d_end != DW + 1) begin
               bad++;
               $display("FAIL burst_gap%0d: got %0d clk, required %0d", i,
                        mon_q[n0+i].a_start - mon_q[n0+i-1].d_end, DW + 1);
            end
         end
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL burst_missing: got %0d outstanding, required 0", sb_q.size());
      end
   endtask

   task automatic test_slow_cen();
      int acc, t, n0;
      cen_div = 4;
      tick(2);
      n0 = mon_q.size();
      push(8'h11, 8'h22, acc);
      wait_idle(1000, t);
      total++;
      if (t - acc < 396 || t - acc > 404) begin
         bad++;
         $display("FAIL slow_total: got %0d clk, required 396..404", t - acc);
      end
      total++;
      if (mon_q.size() != n0 + 1) begin
         bad++;
         $display("FAIL slow_count: got %0d transactions, required 1", mon_q.size() - n0);
      end else begin
         // First strobe starts mid cen-period, so it may be up to one period short.
         total++;
         if (mon_q[n0].d_start - mon_q[n0].a_start < 4 * (STB + AW) - 3 ||
             mon_q[n0].d_start - mon_q[n0].a_start > 4 * (STB + AW)) begin
            bad++;
            $display("FAIL slow_spacing: got %0d clk, required %0d..%0d",
                     mon_q[n0].d_start - mon_q[n0].a_start, 4 * (STB + AW) - 3, 4 * (STB + AW));
         end
         total++;
         if (mon_q[n0].d_start - mon_q[n0].a_end != 4 * AW) begin
            bad++;
            $display("FAIL slow_a_wait: got %0d clk, required %0d", mon_q[n0].d_start - mon_q[n0].a_end, 4 * AW);
         end
         total++;
         if (mon_q[n0].d_end - mon_q[n0].d_start != 4 * STB) begin
            bad++;
            $display("FAIL slow_d_len: got %0d clk, required %0d", mon_q[n0].d_end - mon_q[n0].d_start, 4 * STB);
         end
      end
      cen_div = 1;
   endtask

   task automatic test_cen_freeze();
      int acc, t, n0;
      n0 = mon_q.size();
      cen_div = 0;
      tick(2);
      push(8'h05, 8'h66, acc);
      tick(20);
      total++;
      if ({opll_cs_n, opll_wr_n, opll_a0, opll_d} !== {3'b000, 8'h05}) begin
         bad++;
         $display("FAIL freeze_bus: got cs_n=%b wr_n=%b a0=%b d=%02h, required 0 0 0 05",
                  opll_cs_n, opll_wr_n, opll_a0, opll_d);
      end
      push(8'h06, 8'h77, acc);
      push(8'h07, 8'h88, acc);
      @(negedge clk);
      total++;
      if (fifo_level !== 3'd2) begin
         bad++;
         $display("FAIL freeze_level: got %0d, required 2", fifo_level);
      end
      cen_div = 1;
      wait_idle(1000, t);
      total++;
      if (mon_q.size() != n0 + 3) begin
         bad++;
         $display("FAIL freeze_count: got %0d transactions, required 3", mon_q.size() - n0);
      end
   endtask

   task automatic test_shadow();
      int acc, t, n0, exp_n;
`ifdef OPLL_SHADOW_SKIP_EN
      exp_n = 4;
`else
      exp_n = 5;
`endif
      cen_div = 1;
      n0 = mon_q.size();
      push(8'h20, 8'h0F, acc);
      push(8'h20, 8'h0F, acc);
      push(8'h20, 8'h10, acc);
      push(8'h45, 8'h01, acc);
      push(8'h45, 8'h01, acc);
      wait_idle(2000, t);
      total++;
      if (mon_q.size() - n0 != exp_n) begin
         bad++;
         $display("FAIL shadow_count: got %0d transactions, required %0d", mon_q.size() - n0, exp_n);
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL shadow_missing: got %0d outstanding, required 0", sb_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int acc, n0, w, sc;
      logic [14:0] got;
      logic [14:0] exp;
      exp = {1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
      cen_div = 1;
      n0 = mon_q.size();
      push(8'h12, 8'h34, acc);
      push(8'h13, 8'h35, acc);
      push(8'h14, 8'h36, acc);
      w = 0;
      while (mon_q.size() == n0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      tick(10);
      total++;
      if (fifo_level !== 3'd2 || opll_a0 !== 1'b1 || opll_d !== 8'h34) begin
         bad++;
         $display("FAIL rstmid_pre: got level=%0d a0=%b d=%02h, required 2 1 34", fifo_level, opll_a0, opll_d);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      got = {opll_cs_n, opll_wr_n, opll_a0, opll_d, fifo_level, wr_ready, busy};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL rstmid_async: got %015b required %015b", got, exp);
      end
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      sc = strobe_cnt;
      tick(300);
      total++;
      if (strobe_cnt != sc || busy !== 1'b0 || fifo_level !== 3'd0) begin
         bad++;
         $display("FAIL rstmid_quiet: got %0d strobes busy=%b level=%0d, required 0 0 0",
                  strobe_cnt - sc, busy, fifo_level);
      end
   endtask

   initial begin
      rst = 1'b1;
      wr_valid = 1'b0;
      wr_addr = 8'h00;
      wr_data = 8'h00;
      clear_model();
      tick(3);
      test_reset();
      test_single_write();
      test_burst();
      test_slow_cen();
      test_cen_freeze();
      test_shadow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
